// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell: s = a ^ b ^ c, cout = majority(a, b, c).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    // Pure combinational sum and carry of one bit position.
    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands are captured on start, added one bit per cycle
// through a single full-adder cell, and the result is published on entry to
// DONE. The done pulse follows in the cycle after DONE.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1; it holds there rather than wrapping.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   psum;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_cout;

    // The one and only adder: LSBs of both operand shifters plus the carry flop.
    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c    (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // busy covers the whole operation, including the DONE state.
    assign busy = (state == SHIFT) || (state == DONE);

    // FSM with operand shifters, partial sum, carry, counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter from the MSB end so after WIDTH shifts
                    // the first-computed bit has reached bit 0.
                    psum  <= {fa_s, psum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_cout;
                    if (cnt == CNT_LAST) begin
                        sum   <= {fa_s, psum[WIDTH-1:1]};
                        cout  <= fa_cout;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SHIFT or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result of the last completed addition.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load a and b into shift registers, cin into the carry flop and 0 into the bit counter, and enter SHIFT next cycle.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all registers held.
REQ-015 Each SHIFT cycle SHALL add operand LSBs and the carry flop in exactly one full-adder cell, shift the sum bit into the partial-sum register from the MSB end, right-shift both operands, store the carry-out in the carry flop, and increment the counter.
REQ-016 After the WIDTH-th SHIFT cycle (counter reaching WIDTH-1 during that cycle), the FSM SHALL enter DONE and copy the partial sum and final carry into sum/cout.
REQ-017 In DONE, the block SHALL assert done for exactly one cycle and return unconditionally to IDLE.
REQ-018 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH+1.
REQ-019 Throughput: the earliest next accepted start SHALL be WIDTH+2 cycles after the previous one.
REQ-020 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout set to bit WIDTH of the full sum.
REQ-021 sum and cout SHALL change only on entry to DONE and hold their value through subsequent IDLE/SHIFT periods.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-024 The counter SHALL be $clog2(WIDTH) bits wide (minimum 1) and SHALL NOT wrap within an operation.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear busy, done, sum, cout, the carry flop, the counter, and all shift registers to 0.
REQ-026 A reset asserted mid-operation (SHIFT or DONE) SHALL abort the operation with no done pulse and clear sum to 0.
REQ-027 start in the first cycle after rst_n deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the default-width constant.
REQ-029 The per-bit add SHALL be a single instance of the team's existing full_adder cell (ports a, b, c, s, cout), with no other adder logic.
REQ-030 busy SHALL be decoded from the state register; done SHALL be registered.

Verification
REQ-031 With WIDTH=8, the bench SHALL drive a=0x03, b=0x05, cin=0 and check sum=0x08, cout=0, done 10 cycles after the start edge.
REQ-032 The bench SHALL drive a=0xFF, b=0x01, cin=0 and check sum=0x00, cout=1 (wrap-around).
REQ-033 The bench SHALL drive a=0xAA, b=0x55, cin=1 and check sum=0x00, cout=1 (full carry ripple).
REQ-034 The bench SHALL pulse start=1 with new operands during SHIFT and check that the result is unchanged, no extra done occurs, and busy is continuous.
REQ-035 The bench SHALL assert rst_n=0 during the 4th SHIFT cycle and check busy=0, done=0, sum=0x00 and cout=0; a following 0x10+0x20 SHALL yield 0x30.
REQ-036 The bench SHALL issue back-to-back starts, with start held high, and check done pulses exactly WIDTH+2 cycles apart, each with the correct sum.
